// File: rtl/alu_div_pkg.sv
// Shared types, width defaults and operand-magnitude helper for the ALU sequential divider.
package alu_div_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } div_state_t;

  localparam int unsigned DIV_W_DEFAULT = 32;
  localparam int unsigned DIV_W_MAX     = 64;

  // Magnitude of the low w bits of x; two's-complement negate only for signed negatives.
  function automatic logic [DIV_W_MAX-1:0] abs_mag(input logic [DIV_W_MAX-1:0] x,
                                                   input int unsigned           w,
                                                   input logic                  is_unsigned);
    logic [DIV_W_MAX-1:0] mask;
    logic                 neg;
    mask = {DIV_W_MAX{1'b1}} >> (DIV_W_MAX - w);
    neg  = !is_unsigned && ((x & (DIV_W_MAX'(1) << (w - 1))) != '0);
    return neg ? ((~x + DIV_W_MAX'(1)) & mask) : (x & mask);
  endfunction

endpackage

// File: rtl/alu_seq_divider_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract the divisor.
module div_step
  import alu_div_pkg::*;
#(
  parameter int unsigned N = DIV_W_DEFAULT
) (
  input  logic [N-1:0] rem,
  input  logic         dq_msb,
  input  logic [N-1:0] dmag,
  output logic [N-1:0] rem_nxt_c,
  output logic         q_bit_c
);

  logic [N:0] shifted;
  logic [N:0] diff;

  // Partial remainder kept N+1 bits wide so divisors with the MSB set are handled.
  always_comb begin
    shifted   = {rem, dq_msb};
    diff      = shifted - {1'b0, dmag};
    q_bit_c   = (shifted >= {1'b0, dmag});
    rem_nxt_c = q_bit_c ? N'(diff) : N'(shifted);
  end

endmodule

// File: rtl/alu_seq_divider.sv
// Multi-cycle restoring divider (signed/unsigned), one quotient bit per clock.
// Optional build macro DIV_EARLY_OUT_EN skips the loop when |divisor| > |dividend|.
module alu_seq_divider
  import alu_div_pkg::*;
#(
  parameter int unsigned N = DIV_W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         is_unsigned,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int unsigned CW = $clog2(N);

  div_state_t    state, state_nxt;
  logic [CW-1:0] cnt;
  logic [N-1:0]  wq, wr, dmag;
  logic [N-1:0]  a_mag_c, b_mag_c, rem_nxt_c;
  logic          q_bit_c;
  logic          neg_q, neg_r;
  logic          busy_d, done_d;

  assign a_mag_c = N'(abs_mag(DIV_W_MAX'(dividend), N, is_unsigned));
  assign b_mag_c = N'(abs_mag(DIV_W_MAX'(divisor), N, is_unsigned));

  div_step #(.N(N)) u_step (
    .rem       (wr),
    .dq_msb    (wq[N-1]),
    .dmag      (dmag),
    .rem_nxt_c (rem_nxt_c),
    .q_bit_c   (q_bit_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (divisor == '0) state_nxt = DONE;
`ifdef DIV_EARLY_OUT_EN
          else if (b_mag_c > a_mag_c) state_nxt = FIXUP;
`endif
          else state_nxt = CALC;
        end
      end
      CALC:    if (cnt == '0) state_nxt = FIXUP;
      FIXUP:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Status flags are registered from the next state so they line up with it.
  always_comb begin
    busy_d = 1'b0;
    done_d = 1'b0;
    if (state_nxt == CALC || state_nxt == FIXUP) busy_d = 1'b1;
    if (state_nxt == DONE)                       done_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      cnt         <= '0;
      wq          <= '0;
      wr          <= '0;
      dmag        <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
    end else begin
      busy <= busy_d;
      done <= done_d;
      case (state)
        IDLE: begin
          if (start) begin
            neg_q <= !is_unsigned && (dividend[N-1] ^ divisor[N-1]);
            neg_r <= !is_unsigned && dividend[N-1];
            dmag  <= b_mag_c;
            wq    <= a_mag_c;
            wr    <= '0;
            cnt   <= CW'(N - 1);
`ifdef DIV_EARLY_OUT_EN
            if (b_mag_c > a_mag_c) begin
              wq <= '0;
              wr <= a_mag_c;
            end
`endif
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end
          end
        end
        CALC: begin
          wr  <= rem_nxt_c;
          wq  <= {wq[N-2:0], q_bit_c};
          cnt <= cnt - CW'(1);
        end
        FIXUP: begin
          quotient    <= neg_q ? (~wq + N'(1)) : wq;
          remainder   <= neg_r ? (~wr + N'(1)) : wr;
          div_by_zero <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_divider.sv
// Self-checking bench for alu_seq_divider: vector table, random signed/unsigned vectors and corner sequences.
module tb_alu_seq_divider;

  localparam int N = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          is_unsigned;
  logic [N-1:0]  dividend, divisor;
  logic          busy, done, div_by_zero;
  logic [N-1:0]  quotient, remainder;

  always #5 clk = ~clk;

  alu_seq_divider #(.N(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .is_unsigned (is_unsigned),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  typedef struct {
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dbz;
    int           lat;
  } exp_t;

  typedef struct {
    logic         uns;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dbz;
  } vec_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [N-1:0] mag(input logic uns, input logic [N-1:0] x);
    if (!uns && x[N-1]) return -x;
    return x;
  endfunction

  // Cycles from the accepting edge (counted as 1) to the sample where done is seen.
  function automatic int exp_lat(input logic uns, input logic [N-1:0] a, input logic [N-1:0] b);
    if (b == '0) return 1;
`ifdef DIV_EARLY_OUT_EN
    if (mag(uns, b) > mag(uns, a)) return 2;
`endif
    return N + 2;
  endfunction

  task automatic wait_done(output int cyc);
    cyc = 1;
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic run_div(input logic uns, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [N-1:0] q, input logic [N-1:0] r, input logic dbz);
    exp_t e, g;
    int   cyc;
    e.q = q; e.r = r; e.dbz = dbz; e.lat = exp_lat(uns, a, b);
    sbq.push_back(e);
    @(negedge clk);
    start = 1'b1; is_unsigned = uns; dividend = a; divisor = b;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", 64'(busy), 64'(b != '0));
    wait_done(cyc);
    g = sbq.pop_front();
    check("latency", 64'(cyc), 64'(g.lat));
    check("quotient", 64'(quotient), 64'(g.q));
    check("remainder", 64'(remainder), 64'(g.r));
    check("div_by_zero", 64'(div_by_zero), 64'(g.dbz));
    @(negedge clk);
    check("done_pulse_width", 64'(done), 64'(0));
  endtask

  vec_t vecs[$];

  initial begin
    int cyc, ndone;
    logic [N-1:0] a, b, q, r;
    logic uns;

    vecs.push_back('{1'b1, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0});
    vecs.push_back('{1'b0, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0});
    vecs.push_back('{1'b0, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          1'b0});
    vecs.push_back('{1'b0, 32'hFFFFFFF9,   32'hFFFFFFFE,   32'd3,          32'hFFFFFFFF,   1'b0});
    vecs.push_back('{1'b1, 32'h1234,       32'd0,          32'hFFFFFFFF,   32'h1234,       1'b1});
    vecs.push_back('{1'b0, 32'hFFFFFFF0,   32'd0,          32'hFFFFFFFF,   32'hFFFFFFF0,   1'b1});
    vecs.push_back('{1'b0, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0});
    vecs.push_back('{1'b1, 32'h80000000,   32'hFFFFFFFF,   32'd0,          32'h80000000,   1'b0});
    vecs.push_back('{1'b1, 32'hFFFFFFFF,   32'h80000001,   32'd1,          32'h7FFFFFFE,   1'b0});
    vecs.push_back('{1'b1, 32'd5,          32'd9,          32'd0,          32'd5,          1'b0});
    vecs.push_back('{1'b0, 32'hFFFFFFFB,   32'd9,          32'd0,          32'hFFFFFFFB,   1'b0});
    vecs.push_back('{1'b1, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          1'b0});
    vecs.push_back('{1'b0, 32'd0,          32'd0,          32'hFFFFFFFF,   32'd0,          1'b1});

    start = 1'b0; is_unsigned = 1'b0; dividend = '0; divisor = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_quotient", 64'(quotient), 64'(0));
    check("rst_remainder", 64'(remainder), 64'(0));
    check("rst_div_by_zero", 64'(div_by_zero), 64'(0));
    rst_n = 1'b1;

    foreach (vecs[i])
      run_div(vecs[i].uns, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dbz);

    // Random vectors checked against native division.
    for (int i = 0; i < 16; i++) begin
      uns = 1'($urandom_range(0, 1));
      a   = $urandom;
      b   = (i < 8) ? ($urandom >> $urandom_range(0, 28)) : $urandom;
      if (b == '0) b = 32'd3;
      if (!uns && a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd3;
      if (uns) begin
        q = a / b;
        r = a % b;
      end else begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end
      run_div(uns, a, b, q, r, 1'b0);
    end

    // A start while busy must be ignored.
    begin
      exp_t e, g;
      e.q = 32'd14; e.r = 32'd2; e.dbz = 1'b0; e.lat = N + 2;
      sbq.push_back(e);
      @(negedge clk);
      start = 1'b1; is_unsigned = 1'b1; dividend = 32'd100; divisor = 32'd7;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      start = 1'b1; dividend = 32'd9; divisor = 32'd3;
      @(negedge clk);
      start = 1'b0;
      cyc = 5;
      while (!done && cyc < 200) begin
        @(negedge clk);
        cyc++;
      end
      g = sbq.pop_front();
      check("busy_start_latency", 64'(cyc), 64'(g.lat));
      check("busy_start_quotient", 64'(quotient), 64'(g.q));
      check("busy_start_remainder", 64'(remainder), 64'(g.r));
      ndone = 0;
      repeat (45) begin
        @(negedge clk);
        if (done) ndone++;
      end
      check("busy_start_extra_done", 64'(ndone), 64'(0));
    end

    // Reset in the middle of a divide abandons it.
    @(negedge clk);
    start = 1'b1; is_unsigned = 1'b1; dividend = 32'd100; divisor = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("pre_abort_busy", 64'(busy), 64'(1));
    rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_quotient", 64'(quotient), 64'(0));
    check("abort_remainder", 64'(remainder), 64'(0));
    check("abort_div_by_zero", 64'(div_by_zero), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (45) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("abort_no_done", 64'(ndone), 64'(0));
    run_div(1'b1, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
